// File: rtl/matrix_element_streamer_if.sv
// Element stream from the matrix streamer to its consumer (display/UART formatter).
// The producer drives data, indices and markers; the consumer drives elem_ready.
interface matrix_element_streamer_if #(parameter int ELEM_W = 8);
    logic              elem_valid;
    logic              elem_ready;
    logic [ELEM_W-1:0] elem_data;
    logic [2:0]        elem_row;
    logic [2:0]        elem_col;
    logic              row_last;
    logic              frame_last;

    modport master (
        output elem_valid, elem_data, elem_row, elem_col, row_last, frame_last,
        input  elem_ready
    );

    modport slave (
        input  elem_valid, elem_data, elem_row, elem_col, row_last, frame_last,
        output elem_ready
    );
endinterface

// File: rtl/matrix_element_streamer.sv
// Captures a packed matrix (up to 5x5) in one cycle and streams it out row-major,
// one element per valid/ready transfer, with row/frame end markers.
module matrix_element_streamer #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [2:0]                          m_in,
    input  logic [2:0]                          n_in,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_in,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    matrix_element_streamer_if.master           es
);
    localparam int NUM_ELEM = MAX_DIM * MAX_DIM;
    localparam int MAT_W    = NUM_ELEM * ELEM_W;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t            state, state_n;
    logic [MAT_W-1:0]  mat, mat_n;
    logic [2:0]        m_r, n_r, m_n, n_n;
    logic [2:0]        row, col, row_n, col_n;
    logic              dims_ok, last_beat, vld_n, err_n;
    logic [4:0]        idx;
    logic [ELEM_W-1:0] elems [NUM_ELEM];

    always_comb begin
        state_n   = state;
        mat_n     = mat;
        m_n       = m_r;
        n_n       = n_r;
        row_n     = row;
        col_n     = col;
        err_n     = 1'b0;
        dims_ok   = (m_in != 3'd0) && (m_in <= 3'(MAX_DIM)) &&
                    (n_in != 3'd0) && (n_in <= 3'(MAX_DIM));
        last_beat = (row == m_r - 3'd1) && (col == n_r - 3'd1);
        case (state)
            IDLE: if (start) begin
                if (dims_ok) begin
                    mat_n   = matrix_in;
                    m_n     = m_in;
                    n_n     = n_in;
                    row_n   = 3'd0;
                    col_n   = 3'd0;
                    state_n = SEND;
                end else begin
                    err_n = 1'b1;
                end
            end
            SEND: if (es.elem_ready) begin
                if (last_beat) begin
                    state_n = DONE;
                end else if (col == n_r - 3'd1) begin
                    col_n = 3'd0;
                    row_n = row + 3'd1;
                end else begin
                    col_n = col + 3'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        vld_n = (state_n == SEND);
        idx   = 5'(row_n) * 5'(MAX_DIM) + 5'(col_n);
    end

    // Element view of the next-cycle matrix so the output data register
    // always matches the index registers it is loaded alongside.
    always_comb begin
        for (int i = 0; i < NUM_ELEM; i++)
            elems[i] = mat_n[i*ELEM_W +: ELEM_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mat           <= '0;
            m_r           <= '0;
            n_r           <= '0;
            row           <= '0;
            col           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            es.elem_valid <= 1'b0;
            es.elem_data  <= '0;
            es.elem_row   <= '0;
            es.elem_col   <= '0;
            es.row_last   <= 1'b0;
            es.frame_last <= 1'b0;
        end else begin
            state         <= state_n;
            mat           <= mat_n;
            m_r           <= m_n;
            n_r           <= n_n;
            row           <= row_n;
            col           <= col_n;
            busy          <= (state_n != IDLE);
            done          <= (state_n == DONE);
            err           <= err_n;
            es.elem_valid <= vld_n;
            es.elem_data  <= vld_n ? elems[idx] : '0;
            es.elem_row   <= vld_n ? row_n : 3'd0;
            es.elem_col   <= vld_n ? col_n : 3'd0;
            es.row_last   <= vld_n && (col_n == n_n - 3'd1);
            es.frame_last <= vld_n && (col_n == n_n - 3'd1) && (row_n == m_n - 3'd1);
        end
    end
endmodule

// File: tb/tb_matrix_element_streamer.sv
// Directed bench for matrix_element_streamer: streams, stalls, bad dims,
// async reset mid-frame and start/matrix_in changes while streaming.
module tb_matrix_element_streamer;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   m_in, n_in;
    logic [199:0] matrix_in;
    logic         busy, done, err;
    int           total = 0;
    int           bad   = 0;
    logic [7:0]   exp_d [25];

    matrix_element_streamer_if es ();

    matrix_element_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .m_in      (m_in),
        .n_in      (n_in),
        .matrix_in (matrix_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .es        (es.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // packs exp_d (row-major, n columns) into the 5x5 bus layout
    task automatic pack(input int m, input int n);
        matrix_in = '0;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                matrix_in[(i*5+j)*8 +: 8] = exp_d[i*n+j];
    endtask

    // called at a negedge; leaves us at the negedge of the first cycle after acceptance
    task automatic kick(input int m, input int n);
        m_in  = 3'(m);
        n_in  = 3'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " valid"}, 32'(es.elem_valid), 0);
        chk({tag, " data"},  32'(es.elem_data), 0);
        chk({tag, " row"},   32'(es.elem_row), 0);
        chk({tag, " col"},   32'(es.elem_col), 0);
        chk({tag, " rlast"}, 32'(es.row_last), 0);
        chk({tag, " flast"}, 32'(es.frame_last), 0);
        chk({tag, " busy"},  32'(busy), 0);
        chk({tag, " done"},  32'(done), 0);
        chk({tag, " err"},   32'(err), 0);
    endtask

    // full-rate receive; inj >= 0 fires a stray start with new matrix at that beat
    task automatic recv(input string tag, input int m, input int n, input int inj);
        int busy_cnt = 0;
        for (int b = 0; b < m*n; b++) begin
            if (b == inj) begin
                start = 1'b1; m_in = 3'd1; n_in = 3'd1; matrix_in = {25{8'hEE}};
            end else if (b == inj + 1) begin
                start = 1'b0;
            end
            chk({tag, " valid"}, 32'(es.elem_valid), 1);
            chk({tag, " data"},  32'(es.elem_data), 32'(exp_d[b]));
            chk({tag, " row"},   32'(es.elem_row), 32'(b / n));
            chk({tag, " col"},   32'(es.elem_col), 32'(b % n));
            chk({tag, " rlast"}, 32'(es.row_last), 32'((b % n) == n - 1));
            chk({tag, " flast"}, 32'(es.frame_last), 32'(b == m*n - 1));
            chk({tag, " err"},   32'(err), 0);
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " done"},       32'(done), 1);
        chk({tag, " done valid"}, 32'(es.elem_valid), 0);
        if (busy) busy_cnt++;
        @(negedge clk);
        chk({tag, " done gone"},  32'(done), 0);
        chk({tag, " busy gone"},  32'(busy), 0);
        chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(m*n + 1));
    endtask

    initial begin
        int         xf;
        logic       seen_done;
        logic [7:0] pat [7];

        reset = 1'b0; start = 1'b0; m_in = '0; n_in = '0; matrix_in = '0;
        es.elem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b1;
        @(negedge clk);

        // 2x3 at full rate
        exp_d[0:5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        pack(2, 3);
        kick(2, 3);
        recv("2x3", 2, 3, -1);

        // 1x1: both markers on the only beat
        exp_d[0] = 8'h5A;
        pack(1, 1);
        kick(1, 1);
        recv("1x1", 1, 1, -1);

        // 2x2 with stalls
        exp_d[0:3] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        pack(2, 2);
        pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
        kick(2, 2);
        xf = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            es.elem_ready = (c < 7) ? pat[c][0] : 1'b1;
            if (es.elem_valid) begin
                chk("stall data", 32'(es.elem_data), 32'(exp_d[xf]));
                chk("stall row",  32'(es.elem_row), 32'(xf / 2));
                chk("stall col",  32'(es.elem_col), 32'(xf % 2));
                if (es.elem_ready) xf++;
            end
            @(negedge clk);
        end
        chk("stall xfers", 32'(xf), 4);
        chk("stall done", 32'(seen_done), 1);
        es.elem_ready = 1'b1;
        @(negedge clk);

        // invalid dimensions
        kick(0, 3);
        chk("bad m0 err",   32'(err), 1);
        chk("bad m0 busy",  32'(busy), 0);
        chk("bad m0 valid", 32'(es.elem_valid), 0);
        @(negedge clk);
        chk("bad m0 err gone", 32'(err), 0);
        kick(6, 2);
        chk("bad m6 err",   32'(err), 1);
        chk("bad m6 busy",  32'(busy), 0);
        chk("bad m6 valid", 32'(es.elem_valid), 0);
        @(negedge clk);
        chk("bad m6 err gone", 32'(err), 0);
        chk("bad m6 idle", 32'(busy), 0);

        // 5x5, (i,j) = i*16+j, last element 0x44 in bits [199:192]
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                exp_d[i*5+j] = 8'(i*16 + j);
        pack(5, 5);
        kick(5, 5);
        recv("5x5", 5, 5, -1);

        // async reset after 3 of 6 beats
        exp_d[0:5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        pack(2, 3);
        kick(2, 3);
        repeat (3) @(negedge clk);
        chk("pre-rst data", 32'(es.elem_data), 32'h14);
        #2 reset = 1'b0;
        #1 chk_quiet("async rst");
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post-rst done", 32'(done), 0);
            chk("post-rst valid", 32'(es.elem_valid), 0);
        end
        exp_d[0:5] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        pack(2, 3);
        kick(2, 3);
        recv("restart", 2, 3, -1);

        // stray start with new matrix_in while streaming
        exp_d[0:5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        pack(2, 3);
        kick(2, 3);
        recv("ignore start", 2, 3, 2);
        chk("ignore idle", 32'(es.elem_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_element_streamer.md
# matrix_element_streamer

Serializes a packed matrix (up to 5×5, 8-bit elements) into a stream of single elements over a valid/ready handshake, in row-major order. It is the read-out end of the matrix datapath: results such as the transposed matrix are captured in one cycle and sent element by element to a display or UART formatter. The packed layout is the team's standard: element (i,j) occupies bits [(i*5+j)*8 +: 8] of the 200-bit bus.

## Interface
- `ELEM_W`, 8: element width in bits. Fixed; not overridden.
- `MAX_DIM`, 5: maximum rows/columns. Packed bus width is MAX_DIM*MAX_DIM*ELEM_W = 200.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request to capture and stream one matrix. Sampled only in IDLE.
- `m_in` input 3: row count, valid range 1..5.
- `n_in` input 3: column count, valid range 1..5.
- `matrix_in` input 200: packed matrix. Captured when `start` is accepted.
- `busy` output 1: high from the cycle after acceptance through the `done` cycle.
- `elem_valid` output 1: `elem_data` holds a valid element.
- `elem_ready` input 1: consumer accepts the element. A transfer occurs when `elem_valid && elem_ready`.
- `elem_data` output 8: current element.
- `elem_row` output 3: row index of the current element.
- `elem_col` output 3: column index of the current element.
- `row_last` output 1: current element is the last in its row (col == n-1).
- `frame_last` output 1: current element is the last of the matrix.
- `done` output 1: one-cycle pulse after the final transfer.
- `err` output 1: one-cycle pulse when `start` is given with invalid dimensions.

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE, `start`=1, dims valid:
  - Latch `m_in`, `n_in` and `matrix_in`.
  - Set row=0, col=0 and go to SEND.
- IDLE, `start`=1, m or n is 0 or >5:
  - Pulse `err` for one cycle.
  - Stay in IDLE and do not latch anything.
- SEND:
  - `elem_valid`=1.
  - `elem_data` = latched element (row, col).
  - `row_last` and `frame_last` are decoded from the latched dimensions.
- Transfer not at the end of a row: col+1.
- Transfer with col==n-1 and row<m-1: col=0, row+1.
- Transfer with frame_last: go to DONE and drop `elem_valid`.
- SEND with `elem_ready`=0: all element outputs hold stable. Neither the index nor the data changes.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, then return to IDLE.
- `start` in SEND or DONE is ignored. It causes no err, no relatch and no restart.
- Changes on `matrix_in`, `m_in` or `n_in` after acceptance do not affect the stream.
- All outputs are registered. `elem_row`, `elem_col` and `elem_data` are 0 when `elem_valid`=0.

## Timing
- Reset (reset=0): takes effect immediately, without waiting for a clock edge.
  - State goes to IDLE.
  - All outputs go to 0: busy, elem_valid, elem_data, elem_row, elem_col, row_last, frame_last, done, err.
  - Reset mid-stream abandons the frame; no `done` is issued.
- `start` accepted at edge k: `elem_valid` and `busy` are high from cycle k+1.
- With `elem_ready` held high: one transfer per cycle, m*n cycles total.
  - The final transfer happens at edge k+m*n.
  - `done` is high in cycle k+m*n+1.
  - IDLE is reached at the following edge.
  - The earliest next accepted `start` is sampled at edge k+m*n+2.
- Invalid `start` at edge k: `err` is high in cycle k+1 only; `busy` stays 0.
- 1×1 matrix: the single beat has both `row_last` and `frame_last` high.

## Test plan
- 2×3 matrix, elements row-major 0x11..0x16, `elem_ready`=1:
  - Exactly 6 beats with data 11,12,13,14,15,16.
  - (row,col) = (0,0)…(1,2).
  - `row_last` on beats 3 and 6; `frame_last` only on beat 6.
  - `done` pulse one cycle after beat 6.
- 2×2 matrix with `elem_ready` toggling 1,0,0,1,0,1,1:
  - Exactly 4 transfers.
  - `elem_data` and the indices are stable during every stall.
  - No element is skipped or duplicated.
- `start` with m=0,n=3, then m=6,n=2:
  - Each produces a one-cycle `err`.
  - `elem_valid` and `busy` stay 0.
- 5×5 matrix, element (i,j)=i*16+j:
  - 25 beats; the last beat is 0x44 from bits [199:192] with `frame_last`=1.
  - `busy` is high for 26 cycles.
- Reset pulse after 3 of 6 beats of a 2×3 matrix:
  - All outputs are 0 immediately; no `done`.
  - A new `start` afterwards streams from (0,0) with the newly latched matrix.
- Second `start` plus a changed `matrix_in` during SEND:
  - Ignored; the original data is streamed unchanged.
